adder_seq_ctrl: RTL and testbench
=================================

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 Parameter: NUM_BYTES, default 4, operand width in bytes (legal range 2..16).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 Port: start  input  1  request one operation; sampled only in IDLE.
REQ-005 Port: add_word  input  8*NUM_BYTES  addend, captured on accepted start.
REQ-006 Port: aug_word  input  8*NUM_BYTES  augend, captured on accepted start.
REQ-007 Port: carry_in  input  1  initial carry, captured on accepted start.
REQ-008 Port: sub  input  1  subtract request, captured on accepted start; present only when ADDER_SEQ_SUB_EN is defined.
REQ-009 Port: busy  output  1  high in RUN and DONE.
REQ-010 Port: done  output  1  single-cycle result-valid pulse.
REQ-011 Port: sum_word  output  8*NUM_BYTES  result, held until the next accepted start.
REQ-012 Port: carry_out  output  1  final carry, held like sum_word.
REQ-013 Port: overflow  output  1  signed overflow of the full-width result, held like sum_word.

Function
REQ-014 The block SHALL compute the full-width sum with one shared 8-bit full adder, one byte per cycle, LSB byte first.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE with start=1 SHALL capture operands and carry_in into internal registers, clear the byte index to 0, clear sum_word, and move to RUN.
REQ-017 In RUN, each cycle SHALL write the adder sum into byte[index] of sum_word, register the adder carry-out as the next carry-in, and increment the index.
REQ-018 RUN with index=NUM_BYTES-1 SHALL load carry_out and overflow and move to DONE.
REQ-019 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-020 Latency: start accepted at edge N -> done high during the cycle after edge N+NUM_BYTES; back-to-back starts are accepted every NUM_BYTES+2 cycles.
REQ-021 start while busy=1 SHALL be ignored; captured operands SHALL NOT change mid-operation.
REQ-022 overflow SHALL be 1 iff the MSBs of the two effective operands are equal and the sum MSB differs from them.
REQ-023 The byte index SHALL never exceed NUM_BYTES-1 (no wrap into unused bytes).
REQ-024 Input changes outside an accepted start SHALL have no effect on the outputs.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, index=0, busy=0, done=0, sum_word=0, carry_out=0 and overflow=0.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-027 Macro ADDER_SEQ_SUB_EN defined: the sub port SHALL exist; sub=1 SHALL use ~aug_word as the effective augend and force the initial carry to 1, ignoring carry_in; carry_out=1 SHALL mean no borrow.
REQ-028 Macro ADDER_SEQ_SUB_EN undefined: the sub port and its inverter/mux logic SHALL be absent; the block SHALL only add.

Structure
REQ-029 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the byte width constant 8 SHALL reside in the shared package adder_seq_pkg.
REQ-030 The datapath SHALL be exactly one instance of the existing sub-module adder_full_8bit; no other arithmetic on operand bytes is permitted.

Verification (NUM_BYTES=4)
REQ-031 add=0x000000FF, aug=0x00000001, cin=0 -> sum=0x00000100, cout=0, ovf=0, done at start+5 cycles.
REQ-032 add=0xFFFFFFFF, aug=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0.
REQ-033 add=0x7FFFFFFF, aug=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1; add=0x55555555, aug=0xAAAAAAAA -> sum=0xFFFFFFFF, cout=0.
REQ-034 start pulse again 2 cycles into RUN with different operands -> ignored; first result unchanged; exactly one done pulse.
REQ-035 rst_n low during RUN index 2 -> immediate zero outputs, no done; next start 0x1+0x1 -> sum=0x00000002.
REQ-036 ADDER_SEQ_SUB_EN defined, sub=1: 5-7 -> sum=0xFFFFFFFE, cout=0; 7-5 -> sum=0x00000002, cout=1.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared states, byte width and overflow helper for adder_seq_ctrl
package adder_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_full_8bit.sv
// rtl/adder_full_8bit.sv - 8-bit full adder with carry in and carry out
module adder_full_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [8:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    assign s    = full[7:0];
    assign cout = full[8];

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - byte-serial adder controller; ADDER_SEQ_SUB_EN adds the sub port
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [8*NUM_BYTES-1:0]      add_word,
    input  logic [8*NUM_BYTES-1:0]      aug_word,
    input  logic                        carry_in,
`ifdef ADDER_SEQ_SUB_EN
    input  logic                        sub,
`endif
    output logic                        busy,
    output logic                        done,
    output logic [8*NUM_BYTES-1:0]      sum_word,
    output logic                        carry_out,
    output logic                        overflow
);

    localparam int W     = NUM_BYTES * BYTE_W;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       add_q, add_d;
    logic [W-1:0]       aug_q, aug_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [BYTE_W-1:0]  a_byte, b_byte, add_s;
    logic               add_c;
    int                 byte_lsb;

    always_comb begin
        byte_lsb = int'(idx_q) * BYTE_W;
        a_byte   = add_q[byte_lsb +: BYTE_W];
        b_byte   = aug_q[byte_lsb +: BYTE_W];
    end

    adder_full_8bit u_add (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        add_d   = add_q;
        aug_d   = aug_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    add_d   = add_word;
`ifdef ADDER_SEQ_SUB_EN
                    // Subtraction as a + ~b + 1; carry_out then reads as "no borrow".
                    aug_d   = sub ? ~aug_word : aug_word;
                    carry_d = sub | carry_in;
`else
                    aug_d   = aug_word;
                    carry_d = carry_in;
`endif
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[byte_lsb +: BYTE_W] = add_s;
                carry_d = add_c;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_c;
                    ovf_d   = signed_ovf(a_byte[BYTE_W-1], b_byte[BYTE_W-1], add_s[BYTE_W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            add_q   <= '0;
            aug_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            add_q   <= add_d;
            aug_q   <= aug_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sum_word  = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - directed and random checks of adder_seq_ctrl against an arithmetic model
module tb_adder_seq_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] add_word = '0;
    logic [W-1:0] aug_word = '0;
    logic         carry_in = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] sum_word;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.NUM_BYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .add_word  (add_word),
        .aug_word  (aug_word),
        .carry_in  (carry_in),
`ifdef ADDER_SEQ_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum_word  (sum_word),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic on the effective operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb,
                         output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0]   full;
        logic [W-1:0] beff;
        logic         cieff;
        beff  = b;
        cieff = ci;
`ifdef ADDER_SEQ_SUB_EN
        if (sb) begin
            beff  = ~b;
            cieff = 1'b1;
        end
`else
        if (sb) cieff = ci;
`endif
        full = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, cieff};
        s    = full[W-1:0];
        co   = full[W];
        ov   = (a[W-1] == beff[W-1]) && (s[W-1] != a[W-1]);
    endtask

    // Starts one operation from IDLE and checks timing and result; scrambles inputs while busy.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb);
        logic [W-1:0] es;
        logic         eco, eov;
        int           early;
        model(a, b, ci, sb, es, eco, eov);
        add_word = a;
        aug_word = b;
        carry_in = ci;
        sub      = sb;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        add_word = W'($urandom);
        aug_word = W'($urandom);
        carry_in = 1'($urandom);
        sub      = 1'($urandom);
        early = 0;
        for (int k = 1; k <= NB; k++) begin
            if (done || !busy) early++;
            @(posedge clk);
            @(negedge clk);
        end
        check({tag, " no_early_done"}, 64'(early), 64'd0);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " sum"}, 64'(sum_word), 64'(es));
        check({tag, " cout"}, {63'd0, carry_out}, {63'd0, eco});
        check({tag, " ovf"}, {63'd0, overflow}, {63'd0, eov});
        @(posedge clk);
        @(negedge clk);
        check({tag, " idle"}, {62'd0, busy, done}, 64'd0);
        check({tag, " held"}, 64'(sum_word), 64'(es));
    endtask

    initial begin
        logic [W-1:0] s1, cap_sum;
        logic         c1, o1;
        int           dcount;

        #1;
        check("reset", {29'd0, busy, done, carry_out, overflow, sum_word}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("inc_byte", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("all_ones_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_op("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("alt_bits", 32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 1'b0);
        run_op("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        // Second start 2 cycles into RUN must be ignored.
        model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, s1, c1, o1);
        add_word = 32'h1234_5678;
        aug_word = 32'h1111_1111;
        carry_in = 1'b0;
        sub      = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        dcount = 0;
        cap_sum = '0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 2) begin
                start    = 1'b1;
                add_word = 32'hDEAD_BEEF;
                aug_word = 32'h0BAD_F00D;
            end
            if (k == 4) start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dcount++;
                cap_sum = sum_word;
            end
        end
        check("ignore_start done_count", 64'(dcount), 64'd1);
        check("ignore_start sum", 64'(cap_sum), 64'(s1));
        check("ignore_start held", 64'(sum_word), 64'(s1));

        // Reset at RUN index 2.
        add_word = 32'h0102_0304;
        aug_word = 32'h1010_1010;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset zero", {29'd0, busy, done, carry_out, overflow, sum_word}, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("midrun_reset no_done", 64'(dcount), 64'd0);
        run_op("after_reset", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);

`ifdef ADDER_SEQ_SUB_EN
        run_op("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1);
        run_op("sub_7_5", 32'd7, 32'd5, 1'b0, 1'b1);
        run_op("sub_min", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
